// File: rtl/pipe_stage_reg_hs.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, a
// one-entry skid buffer behind a registered in_ready, flush-to-bubble and a stall counter.
module pipe_stage_reg_hs #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int CTRL_W    = 2,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]            stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                        state_reg, state_next;
    logic                          in_ready_reg;
    logic [CTRL_W-1:0]             main_ctrl_reg, skid_ctrl_reg;
    logic [ADDR_W-1:0]             main_addr_reg, skid_addr_reg;
    logic [NUM_LANES*DATA_W-1:0]   main_data_reg, skid_data_reg;
    logic [CNT_W-1:0]              stall_cnt_reg;

    logic in_xfer, out_xfer;
    logic load_main_in, load_main_skid, load_skid_in;

    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = (state_reg != EMPTY) & out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_next   = FULL;
                    load_skid_in = 1'b1;
                end else if (out_xfer) begin
                    state_next   = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush drops everything held plus any entry accepted this cycle.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b0;
            main_ctrl_reg <= '0;
            main_addr_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_addr_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
            if (load_main_in) begin
                main_ctrl_reg <= in_ctrl;
                main_addr_reg <= in_addr;
            end else if (load_main_skid) begin
                main_ctrl_reg <= skid_ctrl_reg;
                main_addr_reg <= skid_addr_reg;
            end
            if (load_skid_in) begin
                skid_ctrl_reg <= in_ctrl;
                skid_addr_reg <= in_addr;
            end
            if ((state_reg != EMPTY) && !out_ready && (stall_cnt_reg != CNT_MAX))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_data_reg[gi*DATA_W +: DATA_W] <= '0;
                    skid_data_reg[gi*DATA_W +: DATA_W] <= '0;
                end else begin
                    if (load_main_in)
                        main_data_reg[gi*DATA_W +: DATA_W] <= in_data[gi*DATA_W +: DATA_W];
                    else if (load_main_skid)
                        main_data_reg[gi*DATA_W +: DATA_W] <= skid_data_reg[gi*DATA_W +: DATA_W];
                    if (load_skid_in)
                        skid_data_reg[gi*DATA_W +: DATA_W] <= in_data[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

    // Bubbles never carry control bits; address/data keep their last values.
    assign out_valid = (state_reg != EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
    assign out_addr  = main_addr_reg;
    assign out_data  = main_data_reg;
    assign in_ready  = in_ready_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg_hs.sv
// Scoreboard bench for pipe_stage_reg_hs: default instance plus a CNT_W=3 instance
// sharing the same stimulus to exercise stall counter saturation.
module tb_pipe_stage_reg_hs;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_ctrl;
    logic [4:0]  in_addr;
    logic [63:0] in_data;

    logic        in_ready, out_valid;
    logic [1:0]  out_ctrl;
    logic [4:0]  out_addr;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [1:0]  s_out_ctrl;
    logic [4:0]  s_out_addr;
    logic [63:0] s_out_data;
    logic [2:0]  s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg_hs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_addr(out_addr), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg_hs #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_ctrl(s_out_ctrl), .out_addr(s_out_addr), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic [1:0]  c;
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: occupancy count and saturating stall counters.
    int     m_occ   = 0;
    bit     m_ready = 1'b0;
    longint m_stall = 0;
    longint m_sstall = 0;
    bit     m_init  = 1'b0;

    task automatic chk(string nm, longint unsigned act, longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(bit v, logic [63:0] d, bit ordy, bit fl, bit r,
                       logic [1:0] c, logic [4:0] a);
        @(posedge clk);
        #1;
        rst = r; flush = fl; in_valid = v; in_data = d; out_ready = ordy;
        in_ctrl = c; in_addr = a;
        if (!r && !fl && v && in_ready) exp_q.push_back({c, a, d});
    endtask

    always @(negedge clk) begin
        ent_t e;
        int   ox, ix;
        if (m_init) begin
            chk("out_valid", out_valid, m_occ > 0);
            chk("in_ready", in_ready, m_ready);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("sat_out_valid", s_out_valid, m_occ > 0);
            chk("sat_stall_cnt", s_stall_cnt, m_sstall);
            if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
            if (out_valid && out_ready && !rst) begin
                chk("out_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_ctrl", out_ctrl, e.c);
                    chk("out_addr", out_addr, e.a);
                    $display("out xfer: data=%h ctrl=%0d addr=%0d stall=%0d",
                             out_data, out_ctrl, out_addr, stall_cnt);
                end
            end
        end
        if (rst || flush) exp_q.delete();
        if (rst) begin
            m_occ = 0; m_ready = 1'b0; m_stall = 0; m_sstall = 0; m_init = 1'b1;
        end else if (m_init) begin
            ox = (m_occ > 0 && out_ready) ? 1 : 0;
            ix = (in_valid && m_ready) ? 1 : 0;
            if (m_occ > 0 && !out_ready) begin
                if (m_stall < 65535) m_stall++;
                if (m_sstall < 7) m_sstall++;
            end
            m_occ   = flush ? 0 : m_occ - ox + ix;
            m_ready = (m_occ < 2);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 2'b11; in_addr = 5'd7; in_data = 64'hDEADBEEF;

        // Reset with a live input present
        cyc(1, 64'hDEADBEEF, 0, 0, 1, 2'b11, 5'd7);
        cyc(1, 64'hDEADBEEF, 0, 0, 1, 2'b11, 5'd7);
        @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 0);
        cyc(0, 0, 1, 0, 0, 2'b11, 5'd7);

        // Streaming
        for (int i = 1; i <= 4; i++) cyc(1, 64'(i), 1, 0, 0, 2'b11, 5'd7);
        cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);
        cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);

        // Backpressure into the skid, then release
        cyc(1, 64'h10, 0, 0, 0, 2'b01, 5'd3);
        cyc(1, 64'h20, 0, 0, 0, 2'b10, 5'd4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 2'b00, 5'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);

        // Flush while FULL, with a simultaneous input that must be dropped
        cyc(1, 64'h50, 0, 0, 0, 2'b11, 5'd9);
        cyc(1, 64'h60, 0, 0, 0, 2'b11, 5'd9);
        cyc(1, 64'h30, 0, 1, 0, 2'b11, 5'd9);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);

        // Flush coinciding with an output transfer
        cyc(1, 64'h40, 0, 0, 0, 2'b11, 5'd1);
        cyc(0, 0, 1, 1, 0, 2'b00, 5'd0);
        cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);

        // Long stall saturates the 3-bit counter
        cyc(1, 64'h70, 0, 0, 0, 2'b11, 5'd2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 2'b00, 5'd0);
        @(negedge clk);
        chk("sat_hold_7", s_stall_cnt, 7);
        cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, {32'($urandom), 32'($urandom)},
                $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0, 0,
                2'($urandom), 5'($urandom));

        // Drain and confirm nothing was lost
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 2'b00, 5'd0);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
